// File: rtl/chain_score_scheduler.sv
// Chaining score scheduler: scans up to N_PRED predecessors of an anchor through an
// external score pipe and keeps the best f(i). Optional reference-gap limit: SCHED_MAXGAP_EN.
module chain_score_scheduler #(
   parameter int N_PRED   = 64,
   parameter int PIPE_LAT = 7,
   parameter int IDX_W    = 16,
   parameter int MAX_GAP  = 5000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [IDX_W-1:0] cur_idx,
   input  logic [31:0]      cur_rx,
   input  logic [31:0]      cur_qx,
   input  logic [31:0]      cur_w,
   input  logic [31:0]      w_avg,
   output logic             rd_en,
   output logic [IDX_W-1:0] rd_addr,
   input  logic [31:0]      rd_ry,
   input  logic [31:0]      rd_qy,
   input  logic [31:0]      rd_score,
   output logic [31:0]      ps_riX,
   output logic [31:0]      ps_riY,
   output logic [31:0]      ps_qiX,
   output logic [31:0]      ps_qiY,
   output logic [31:0]      ps_W,
   output logic [31:0]      ps_W_avg,
   input  logic [31:0]      ps_result,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [31:0]      best_score,
   output logic [IDX_W-1:0] best_pred
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [IDX_W-1:0] NPredW   = IDX_W'(N_PRED);
   localparam logic [31:0]      MaxGapW  = 32'(MAX_GAP);
`ifdef SCHED_MAXGAP_EN
   localparam bit GapEn = 1'b1;
`else
   localparam bit GapEn = 1'b0;
`endif

   typedef struct packed {
      logic             vld;
      logic             elig;
      logic             last;
      logic [IDX_W-1:0] j;
      logic [31:0]      score;
   } tag_t;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             rd_en_q, rd_en_d;
   logic [IDX_W-1:0] rd_addr_q, rd_addr_d;
   logic             pend_q, pend_d;
   logic             pend_last_q, pend_last_d;
   logic [IDX_W-1:0] pend_j_q, pend_j_d;
   logic [31:0]      cur_rx_q, cur_rx_d, cur_qx_q, cur_qx_d;
   logic [31:0]      cur_w_q, cur_w_d, w_avg_q, w_avg_d;
   logic [31:0]      ps_rix_q, ps_rix_d, ps_riy_q, ps_riy_d;
   logic [31:0]      ps_qix_q, ps_qix_d, ps_qiy_q, ps_qiy_d;
   logic [31:0]      ps_w_q, ps_w_d, ps_wavg_q, ps_wavg_d;
   logic [31:0]      best_score_q, best_score_d;
   logic [IDX_W-1:0] best_pred_q, best_pred_d;
   tag_t             tag_q [PIPE_LAT];
   tag_t             tag_d [PIPE_LAT];

   logic [IDX_W-1:0] n_start;
   logic [31:0]      gap;
   logic             elig;
   logic [32:0]      sum;
   logic [31:0]      cand;
   tag_t             tag_out;

   assign n_start = (cur_idx > NPredW) ? NPredW : cur_idx;
   assign gap     = cur_rx_q - rd_ry;
   assign elig    = (rd_ry < cur_rx_q) && (rd_qy < cur_qx_q) && (!GapEn || (gap <= MaxGapW));
   assign tag_out = tag_q[PIPE_LAT-1];

   // Exiting tag meets its pipe result; the 33-bit sum is clamped back into 32-bit signed.
   always_comb begin
      sum = {tag_out.score[31], tag_out.score} + {ps_result[31], ps_result};
      if (sum[32] != sum[31]) begin
         cand = sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         cand = sum[31:0];
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      rd_en_d      = rd_en_q;
      rd_addr_d    = rd_addr_q;
      cur_rx_d     = cur_rx_q;
      cur_qx_d     = cur_qx_q;
      cur_w_d      = cur_w_q;
      w_avg_d      = w_avg_q;
      best_score_d = best_score_q;
      best_pred_d  = best_pred_q;
      pend_d       = rd_en_q;
      pend_j_d     = rd_addr_q;
      pend_last_d  = rd_en_q && (cnt_q == IDX_W'(1));
      ps_rix_d     = ps_rix_q;
      ps_riy_d     = ps_riy_q;
      ps_qix_d     = ps_qix_q;
      ps_qiy_d     = ps_qiy_q;
      ps_w_d       = ps_w_q;
      ps_wavg_d    = ps_wavg_q;

      if (pend_q) begin
         ps_rix_d  = cur_rx_q;
         ps_riy_d  = rd_ry;
         ps_qix_d  = cur_qx_q;
         ps_qiy_d  = rd_qy;
         ps_w_d    = cur_w_q;
         ps_wavg_d = w_avg_q;
      end

      tag_d[0] = '{vld: pend_q, elig: elig, last: pend_last_q, j: pend_j_q, score: rd_score};
      for (int k = 1; k < PIPE_LAT; k++) begin
         tag_d[k] = tag_q[k-1];
      end

      // Strict compare: on a tie the earlier-issued (larger) j is kept.
      if (tag_out.vld && tag_out.elig && ($signed(cand) > $signed(best_score_q))) begin
         best_score_d = cand;
         best_pred_d  = tag_out.j;
      end

      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               cur_rx_d     = cur_rx;
               cur_qx_d     = cur_qx;
               cur_w_d      = cur_w;
               w_avg_d      = w_avg;
               best_score_d = cur_w;
               best_pred_d  = '1;
               cnt_d        = n_start;
               if (n_start == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_ISSUE;
                  rd_en_d   = 1'b1;
                  rd_addr_d = cur_idx - 1'b1;
               end
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == IDX_W'(1)) begin
               rd_en_d = 1'b0;
               state_d = S_DRAIN;
            end else begin
               rd_addr_d = rd_addr_q - 1'b1;
            end
         end
         S_DRAIN: begin
            if (tag_out.vld && tag_out.last) begin
               state_d = S_DONE;
            end
         end
         default: begin
            if (done_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         pend_j_q     <= '0;
         cur_rx_q     <= '0;
         cur_qx_q     <= '0;
         cur_w_q      <= '0;
         w_avg_q      <= '0;
         ps_rix_q     <= '0;
         ps_riy_q     <= '0;
         ps_qix_q     <= '0;
         ps_qiy_q     <= '0;
         ps_w_q       <= '0;
         ps_wavg_q    <= '0;
         best_score_q <= '0;
         best_pred_q  <= '1;
         for (int k = 0; k < PIPE_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         pend_q       <= pend_d;
         pend_last_q  <= pend_last_d;
         pend_j_q     <= pend_j_d;
         cur_rx_q     <= cur_rx_d;
         cur_qx_q     <= cur_qx_d;
         cur_w_q      <= cur_w_d;
         w_avg_q      <= w_avg_d;
         ps_rix_q     <= ps_rix_d;
         ps_riy_q     <= ps_riy_d;
         ps_qix_q     <= ps_qix_d;
         ps_qiy_q     <= ps_qiy_d;
         ps_w_q       <= ps_w_d;
         ps_wavg_q    <= ps_wavg_d;
         best_score_q <= best_score_d;
         best_pred_q  <= best_pred_d;
         tag_q        <= tag_d;
      end
   end

   assign start_ready = (state_q == S_IDLE);
   assign done_valid  = (state_q == S_DONE);
   assign rd_en       = rd_en_q;
   assign rd_addr     = rd_addr_q;
   assign ps_riX      = ps_rix_q;
   assign ps_riY      = ps_riy_q;
   assign ps_qiX      = ps_qix_q;
   assign ps_qiY      = ps_qiy_q;
   assign ps_W        = ps_w_q;
   assign ps_W_avg    = ps_wavg_q;
   assign best_score  = best_score_q;
   assign best_pred   = best_pred_q;

endmodule

// File: tb/tb_chain_score_scheduler.sv
// Directed bench for chain_score_scheduler: anchor memory model, constant score-pipe stub,
// and a scoreboard of expected results and read addresses.
module tb_chain_score_scheduler;

   localparam int N_PRED   = 64;
   localparam int PIPE_LAT = 7;
   localparam int IDX_W    = 16;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [IDX_W-1:0] cur_idx = '0;
   logic [31:0]      cur_rx = '0, cur_qx = '0, cur_w = '0, w_avg = '0;
   logic             rd_en;
   logic [IDX_W-1:0] rd_addr;
   logic [31:0]      rd_ry = '0, rd_qy = '0, rd_score = '0;
   logic [31:0]      ps_riX, ps_riY, ps_qiX, ps_qiY, ps_W, ps_W_avg;
   logic [31:0]      ps_result = '0;
   logic             done_valid;
   logic             done_ready = 1'b0;
   logic [31:0]      best_score;
   logic [IDX_W-1:0] best_pred;

   typedef struct {
      logic [31:0]      score;
      logic [IDX_W-1:0] pred;
      int               lat;
      int               nrd;
      logic [31:0]      lastRy;
      logic [31:0]      rx;
      logic [31:0]      qx;
      logic [31:0]      w;
      logic [31:0]      wavg;
   } exp_t;

   exp_t             expQ[$];
   logic [IDX_W-1:0] expAddrQ[$];
   logic [31:0]      memRy [0:127];
   logic [31:0]      memQy [0:127];
   logic [31:0]      memScore [0:127];
   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   int               readCnt = 0;
   int               startCyc = 0;

   chain_score_scheduler #(
      .N_PRED(N_PRED), .PIPE_LAT(PIPE_LAT), .IDX_W(IDX_W), .MAX_GAP(5000)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .cur_idx(cur_idx), .cur_rx(cur_rx), .cur_qx(cur_qx), .cur_w(cur_w), .w_avg(w_avg),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_ry(rd_ry), .rd_qy(rd_qy), .rd_score(rd_score),
      .ps_riX(ps_riX), .ps_riY(ps_riY), .ps_qiX(ps_qiX), .ps_qiY(ps_qiY),
      .ps_W(ps_W), .ps_W_avg(ps_W_avg), .ps_result(ps_result),
      .done_valid(done_valid), .done_ready(done_ready),
      .best_score(best_score), .best_pred(best_pred)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Anchor memory: registered read, data valid the cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en === 1'b1) begin
         rd_ry    <= memRy[rd_addr[6:0]];
         rd_qy    <= memQy[rd_addr[6:0]];
         rd_score <= memScore[rd_addr[6:0]];
      end
   end

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Every read is matched against the next expected predecessor address.
   always @(negedge clk) begin
      logic [IDX_W-1:0] ea;
      if (reset_n === 1'b1 && rd_en === 1'b1) begin
         readCnt++;
         if (expAddrQ.size() > 0) begin
            ea = expAddrQ.pop_front();
            checkEq("rd_addr", 64'(rd_addr), 64'(ea));
         end
      end
   end

   task automatic applyStimulus(input int idx, input logic [31:0] rx, input logic [31:0] qx,
                                input logic [31:0] w, input logic [31:0] wavg,
                                input logic [31:0] stub);
      exp_t   e;
      int     n, j, best, cand;
      longint sum;
      bit     el;
      n    = (idx > N_PRED) ? N_PRED : idx;
      best = int'(w);
      e.pred = '1;
      for (int k = 1; k <= n; k++) begin
         j  = idx - k;
         el = (memRy[j] < rx) && (memQy[j] < qx);
`ifdef SCHED_MAXGAP_EN
         el = el && ((rx - memRy[j]) <= 32'd5000);
`endif
         if (el) begin
            sum = longint'(int'(memScore[j])) + longint'(int'(stub));
            if (sum > 64'sd2147483647) sum = 64'sd2147483647;
            if (sum < -64'sd2147483648) sum = -64'sd2147483648;
            cand = int'(sum);
            if (cand > best) begin
               best   = cand;
               e.pred = IDX_W'(j);
            end
         end
         expAddrQ.push_back(IDX_W'(j));
      end
      e.score  = 32'(best);
      e.nrd    = n;
      e.lat    = (n == 0) ? 1 : n + PIPE_LAT + 2;
      e.lastRy = (n > 0) ? memRy[idx - n] : 32'd0;
      e.rx = rx; e.qx = qx; e.w = w; e.wavg = wavg;
      expQ.push_back(e);

      ps_result   = stub;
      readCnt     = 0;
      cur_idx     = IDX_W'(idx);
      cur_rx      = rx;
      cur_qx      = qx;
      cur_w       = w;
      w_avg       = wavg;
      start_valid = 1'b1;
      @(posedge clk); #1;
      startCyc    = cyc;
      start_valid = 1'b0;
      checkEq("start_ready_busy", 64'(start_ready), 64'd0);
   endtask

   task automatic checkOutput(input string name);
      exp_t e;
      int   waited;
      e = expQ.pop_front();
      waited = 0;
      while (done_valid !== 1'b1 && waited < 300) begin
         @(posedge clk); #1;
         waited++;
      end
      checkEq({name, "_done_seen"}, 64'(done_valid), 64'd1);
      checkEq({name, "_latency"}, 64'(cyc - startCyc + 1), 64'(e.lat));
      checkEq({name, "_best_score"}, 64'(best_score), 64'(e.score));
      checkEq({name, "_best_pred"}, 64'(best_pred), 64'(e.pred));
      checkEq({name, "_reads"}, 64'(readCnt), 64'(e.nrd));
      if (e.nrd > 0) begin
         checkEq({name, "_ps_riY"}, 64'(ps_riY), 64'(e.lastRy));
         checkEq({name, "_ps_riX"}, 64'(ps_riX), 64'(e.rx));
         checkEq({name, "_ps_qiX"}, 64'(ps_qiX), 64'(e.qx));
         checkEq({name, "_ps_W"}, 64'(ps_W), 64'(e.w));
         checkEq({name, "_ps_W_avg"}, 64'(ps_W_avg), 64'(e.wavg));
      end
      @(posedge clk); #1;
      checkEq({name, "_hold_valid"}, 64'(done_valid), 64'd1);
      checkEq({name, "_hold_score"}, 64'(best_score), 64'(e.score));
      done_ready = 1'b1;
      @(posedge clk); #1;
      done_ready = 1'b0;
      checkEq({name, "_start_ready_after"}, 64'(start_ready), 64'd1);
      checkEq({name, "_done_cleared"}, 64'(done_valid), 64'd0);
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      #3;
      checkEq("rst_rd_en", 64'(rd_en), 64'd0);
      checkEq("rst_rd_addr", 64'(rd_addr), 64'd0);
      checkEq("rst_ps_riX", 64'(ps_riX), 64'd0);
      checkEq("rst_ps_qiY", 64'(ps_qiY), 64'd0);
      checkEq("rst_done_valid", 64'(done_valid), 64'd0);
      checkEq("rst_best_score", 64'(best_score), 64'd0);
      checkEq("rst_best_pred", 64'(best_pred), 64'hFFFF);
      @(posedge clk); #1;
      reset_n = 1'b1;
      checkEq("rst_start_ready", 64'(start_ready), 64'd1);
   endtask

   initial begin
      for (int k = 0; k < 128; k++) begin
         memRy[k] = '0; memQy[k] = '0; memScore[k] = '0;
      end
      @(posedge clk); #1;
      doReset();

      // Anchor 0: no predecessors.
      applyStimulus(0, 32'd100, 32'd100, 32'd15, 32'd9, 32'd10);
      checkOutput("i0");

      // Anchor 3: tie between j1 and j0, plus an ignored start while busy.
      memRy[2] = 32'd10; memQy[2] = 32'd10; memScore[2] = 32'd20;
      memRy[1] = 32'd20; memQy[1] = 32'd20; memScore[1] = 32'd40;
      memRy[0] = 32'd30; memQy[0] = 32'd30; memScore[0] = 32'd40;
      applyStimulus(3, 32'd1000, 32'd1000, 32'd5, 32'd7, 32'd10);
      cur_idx = 16'd50; cur_w = 32'd999; start_valid = 1'b1;
      @(posedge clk); #1;
      checkEq("busy_start_ready", 64'(start_ready), 64'd0);
      @(posedge clk); #1;
      start_valid = 1'b0;
      checkOutput("i3_tie");

      // Anchor 2: equal reference coordinate and larger query coordinate are both rejected.
      memRy[1] = 32'd500; memQy[1] = 32'd10;  memScore[1] = 32'd1000;
      memRy[0] = 32'd10;  memQy[0] = 32'd600; memScore[0] = 32'd1000;
      applyStimulus(2, 32'd500, 32'd500, 32'd7, 32'd1, 32'd10);
      checkOutput("i2_inelig");

      // Anchor 1: positive overflow saturates.
      memRy[0] = 32'd1; memQy[0] = 32'd1; memScore[0] = 32'h7FFF_FFF0;
      applyStimulus(1, 32'd50, 32'd50, 32'd3, 32'd1, 32'h100);
      checkOutput("i1_sat");

      // Anchor 100: window capped at N_PRED, mixed scores and eligibility.
      for (int k = 0; k < 100; k++) begin
         memRy[k]    = 32'(k * 10);
         memQy[k]    = 32'(k * 7 + ((k % 3 == 0) ? 5000 : 0));
         memScore[k] = 32'(((k * 37) % 101) - 50);
      end
      applyStimulus(100, 32'd2000, 32'd2000, 32'hFFFF_FF9C, 32'd12, 32'd3);
      checkOutput("i100_window");

      // Abort mid-issue, then a fresh anchor that stale tags would corrupt.
      for (int k = 7; k < 10; k++) begin
         memRy[k] = 32'd5; memQy[k] = 32'd5; memScore[k] = 32'h4000_0000;
      end
      memRy[2] = 32'd10; memQy[2] = 32'd10; memScore[2] = 32'd11;
      memRy[1] = 32'd20; memQy[1] = 32'd20; memScore[1] = 32'd60;
      memRy[0] = 32'd30; memQy[0] = 32'd30; memScore[0] = 32'hFFFF_FFFB;
      applyStimulus(10, 32'd900, 32'd900, 32'd0, 32'd2, 32'd10);
      @(posedge clk); #1;
      @(posedge clk); #1;
      doReset();
      expQ.delete();
      expAddrQ.delete();
      applyStimulus(3, 32'd900, 32'd900, 32'd0, 32'd2, 32'd10);
      checkOutput("after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chain_score_scheduler.md
CHAIN_SCORE_SCHEDULER -- requirements
Module: chain_score_scheduler

Interface
REQ-001 Parameter N_PRED, default 64: maximum predecessors examined per anchor.
REQ-002 Parameter PIPE_LAT, default 7: cycles from score-pipe input to ps_result valid.
REQ-003 Parameter IDX_W, default 16: anchor index width.
REQ-004 Parameter MAX_GAP, default 5000: reference-gap limit, used only under REQ-028.
REQ-005 Ports, in this order:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  new anchor request.
- start_ready  out  1  scheduler can accept an anchor.
- cur_idx  in  IDX_W  anchor index i.
- cur_rx, cur_qx  in  32  anchor i reference/query coordinates.
- cur_w  in  32  anchor i weight.
- w_avg  in  32  average seed weight.
- rd_en  out  1  anchor-memory read strobe.
- rd_addr  out  IDX_W  predecessor index j.
- rd_ry, rd_qy  in  32  anchor j coordinates, valid 1 cycle after rd_en.
- rd_score  in  32  f(j), signed, valid 1 cycle after rd_en.
- ps_riX, ps_riY, ps_qiX, ps_qiY, ps_W, ps_W_avg  out  32  score-pipe operands.
- ps_result  in  32  score-pipe output, signed.
- done_valid  out  1  result available.
- done_ready  in  1  consumer accepts the result.
- best_score  out  32  f(i), signed.
- best_pred  out  IDX_W  best predecessor index; all-ones if none.

Function
REQ-006 States: IDLE, ISSUE, DRAIN, DONE; start_ready SHALL be 1 only in IDLE.
REQ-007 Start handshake: start_valid && start_ready latches cur_* and w_avg.
REQ-008 On start: n = min(cur_idx, N_PRED); best_score = cur_w; best_pred = all-ones.
REQ-009 On start, go to DONE if n == 0; otherwise go to ISSUE.
REQ-010 ISSUE: rd_en = 1 each cycle with rd_addr = i-1, i-2, ..., i-n (one per cycle); go to DRAIN after the n-th read.
REQ-011 Cycle after each read: ps_riX = cur_rx, ps_riY = rd_ry, ps_qiX = cur_qx, ps_qiY = rd_qy, ps_W = cur_w, ps_W_avg = w_avg.
REQ-012 Operands are registered; ps_* hold their last value when no issue is in flight.
REQ-013 A predecessor is eligible iff rd_ry < cur_rx and rd_qy < cur_qx (unsigned).
REQ-014 A tag shift register of depth PIPE_LAT carries eligible flag, j and rd_score alongside each issue.
REQ-015 When a tag with eligible = 1 exits the shift register, cand = rd_score + ps_result, 33-bit signed, saturated to 32-bit signed.
REQ-016 cand > best_score SHALL update best_score/best_pred; ties keep the earlier-issued (larger) j.
REQ-017 DRAIN: go to DONE the cycle after the last tag exits.
REQ-018 DONE: done_valid = 1 with stable best_score/best_pred until done_ready; then go to IDLE.
REQ-019 Total latency start->done_valid = n + PIPE_LAT + 2 cycles for n > 0; 1 cycle for n = 0.
REQ-020 Back-to-back: start_ready SHALL be 1 the cycle after the done handshake.
REQ-021 start_valid outside IDLE is ignored; no queueing.
REQ-022 Ineligible predecessors still consume one issue slot and PIPE_LAT cycles.

Reset
REQ-023 reset_n low asynchronously forces IDLE and clears the tag shift register.
REQ-024 Reset values: start_ready 1 after release, rd_en 0, rd_addr 0, all ps_* 0, done_valid 0, best_score 0, best_pred all-ones.
REQ-025 Reset mid-ISSUE/DRAIN discards in-flight tags; no done_valid for the aborted anchor.
REQ-026 Results arriving on ps_result after reset are ignored.
REQ-027 First start is accepted on the first clk edge with reset_n high.

Configuration
REQ-028 Macro SCHED_MAXGAP_EN defined: eligibility additionally requires (cur_rx - rd_ry) <= MAX_GAP.
REQ-029 SCHED_MAXGAP_EN undefined: only the REQ-013 ordering test applies; MAX_GAP is unused.

Verification
REQ-030 Start i=0, cur_w=15 -> done_valid after 1 cycle, best_score=15, best_pred=all-ones, no rd_en.
REQ-031 i=3, all preds eligible, stub pipe returns 10, rd_score {j2:20, j1:40, j0:40} -> best_score=50, best_pred=1 (tie keeps j1), done at 3+PIPE_LAT+2 cycles.
REQ-032 i=100, N_PRED=64 -> exactly 64 reads, rd_addr 99..36, then DRAIN.
REQ-033 Pred rd_ry=cur_rx -> ineligible; best_score stays cur_w.
REQ-034 rd_score=0x7FFFFFF0, ps_result=0x100 -> best_score=0x7FFFFFFF (saturated).
REQ-035 reset_n low in cycle 3 of ISSUE -> IDLE, done_valid 0; next anchor's result is unaffected by stale tags.
